// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the unified instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int AW_DEF       = 6;
  localparam int DW_DEF       = 32;
  localparam int MAX_WAIT_DEF = 3;

  // Which port owns the read/ack returning from memory this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D_RD = 2'd2,
    OWN_D_WR = 2'd3
  } own_e;

endpackage

// File: rtl/starve_counter.sv
// Saturating count of consecutive fetch denials; sat flags that the fetch must win next.
module starve_counter #(
  parameter  int MAX_WAIT = 3,
  localparam int CW       = $clog2(MAX_WAIT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          sat
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign sat = (cnt_q == CW'(MAX_WAIT));
  assign cnt = cnt_q;

  // Clear has priority over increment; increment stops at MAX_WAIT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one synchronous-read memory between instruction fetch and load/store.
// Data wins by default; a fetch starved MAX_WAIT cycles in a row is forced through.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int AW       = AW_DEF,
  parameter  int DW       = DW_DEF,
  parameter  int MAX_WAIT = MAX_WAIT_DEF,
  localparam int CW       = $clog2(MAX_WAIT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_stall,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_stall,
  output logic          d_valid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output own_e          dbg_own_o,
  output logic [CW-1:0] dbg_starve_o
);

  // Handshake: a request is accepted in the cycle its stall is low; the requester
  // holds req/addr/wdata/we while stalled, and the response arrives one cycle later
  // as a single-cycle valid. Nothing is latched here.
  logic force_if;
  logic grant_d;
  logic grant_if;
  logic starve_sat;
  logic starve_inc;
  logic starve_clr;
  own_e own_q;
  own_e own_d;

  assign force_if = if_req && starve_sat;
  assign grant_d  = rst && d_req && !force_if;
  assign grant_if = rst && if_req && !grant_d;

  assign if_stall = if_req && !grant_if;
  assign d_stall  = d_req && !grant_d;

  assign starve_inc = if_req && !grant_if;
  assign starve_clr = grant_if || !if_req;

  starve_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (starve_inc),
    .clr (starve_clr),
    .cnt (dbg_starve_o),
    .sat (starve_sat)
  );

  always_comb begin
    mem_en    = grant_d || grant_if;
    mem_we    = grant_d && d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_d) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (grant_if) begin
      mem_addr  = if_addr;
    end
  end

  always_comb begin
    own_d = OWN_NONE;
    if (grant_if) begin
      own_d = OWN_IF;
    end else if (grant_d) begin
      own_d = d_we ? OWN_D_WR : OWN_D_RD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      own_q <= OWN_NONE;
    end else begin
      own_q <= own_d;
    end
  end

  // Responses are gated by rst so a grant just before reset never surfaces.
  assign if_valid  = rst && (own_q == OWN_IF);
  assign d_valid   = rst && ((own_q == OWN_D_RD) || (own_q == OWN_D_WR));
  assign if_rdata  = if_valid ? mem_rdata : '0;
  assign d_rdata   = (rst && (own_q == OWN_D_RD)) ? mem_rdata : '0;
  assign dbg_own_o = own_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: per-cycle grant checks plus a response scoreboard.
module tb_unified_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int CW = 2;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_stall;
  logic          if_valid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_stall;
  logic          d_valid;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  own_e          dbg_own_o;
  logic [CW-1:0] dbg_starve_o;

  int checks = 0;
  int errors = 0;
  // {is_fetch, data}
  logic [DW:0] exp_q[$];

  unified_mem_arbiter #(
    .AW (AW), .DW (DW), .MAX_WAIT (3)
  ) dut (
    .clk (clk), .rst (rst),
    .if_req (if_req), .if_addr (if_addr), .if_stall (if_stall),
    .if_valid (if_valid), .if_rdata (if_rdata),
    .d_req (d_req), .d_we (d_we), .d_addr (d_addr), .d_wdata (d_wdata),
    .d_stall (d_stall), .d_valid (d_valid), .d_rdata (d_rdata),
    .mem_en (mem_en), .mem_we (mem_we), .mem_addr (mem_addr),
    .mem_wdata (mem_wdata), .mem_rdata (mem_rdata),
    .dbg_own_o (dbg_own_o), .dbg_starve_o (dbg_starve_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: unwritten word a reads as 0xA0000000 | a.
  logic [DW-1:0] mem [64];
  bit            written [64];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr]     <= mem_wdata;
        written[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= written[mem_addr] ? mem[mem_addr] : (32'hA000_0000 | 32'(mem_addr));
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // g: hand-computed grant (0 none, 1 fetch, 2 load, 3 store); rd: expected response data.
  // exp_cnt < 0 skips the counter check; kill suppresses the response (reset follows).
  task automatic step(input logic r, input logic ir, input logic [AW-1:0] ia,
                      input logic dr, input logic dwe, input logic [AW-1:0] da,
                      input logic [DW-1:0] dwd, input int g, input logic [DW-1:0] rd,
                      input int exp_cnt, input bit kill);
    logic [AW-1:0] ea;
    rst = r; if_req = ir; if_addr = ia;
    d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    ea = (g == 1) ? ia : (g >= 2) ? da : '0;
    @(negedge clk);
    chk("if_stall", 64'(if_stall), 64'(ir && (g != 1)));
    chk("d_stall", 64'(d_stall), 64'(dr && (g < 2)));
    chk("mem_en", 64'(mem_en), 64'(g != 0));
    chk("mem_we", 64'(mem_we), 64'(g == 3));
    chk("mem_addr", 64'(mem_addr), 64'(ea));
    chk("mem_wdata", 64'(mem_wdata), (g >= 2) ? 64'(dwd) : 64'd0);
    if (exp_cnt >= 0) chk("starve_cnt", 64'(dbg_starve_o), 64'(exp_cnt));
    if (!kill) begin
      case (g)
        1: exp_q.push_back({1'b1, rd});
        2: exp_q.push_back({1'b0, rd});
        3: exp_q.push_back({1'b0, 32'h0});
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  task automatic mon_pop(input logic is_if, input logic [DW-1:0] data);
    logic [DW:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_resp: got port_if=%0d data=%0h expected no response at %0t",
               is_if, data, $time);
    end else begin
      e = exp_q.pop_front();
      chk("resp_port", 64'(is_if), 64'(e[DW]));
      chk("resp_data", 64'(data), 64'(e[DW-1:0]));
    end
  endtask

  always @(negedge clk) begin
    if (if_valid && d_valid) begin
      checks++;
      errors++;
      $display("FAIL dual_valid: got if_valid=1 d_valid=1 expected at most one at %0t", $time);
    end
    if (if_valid) mon_pop(1'b1, if_rdata);
    if (d_valid) mon_pop(1'b0, d_rdata);
  end

  // Conflict vectors, both ports requesting continuously.
  int conf_g   [8] = '{2, 2, 2, 1, 2, 2, 2, 1};
  int conf_cnt [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    rst = 1'b0; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    @(posedge clk);
    #1;

    // Reset held with both requests up
    repeat (3) step(0, 1, 6'd10, 1, 0, 6'd20, 32'h0, 0, 32'h0, 0, 0);

    // Conflict: D D D IF D D D IF
    for (int i = 0; i < 8; i++)
      step(1, 1, 6'd10, 1, 0, 6'd20, 32'h0, conf_g[i],
           (conf_g[i] == 1) ? 32'hA000_000A : 32'hA000_0014, conf_cnt[i], 0);
    step(1, 0, 6'd0, 0, 0, 6'd0, 32'h0, 0, 32'h0, 0, 0);

    // Fetch only
    step(1, 1, 6'd0, 0, 0, 6'd0, 32'h0, 1, 32'hA000_0000, 0, 0);
    step(1, 1, 6'd1, 0, 0, 6'd0, 32'h0, 1, 32'hA000_0001, 0, 0);
    step(1, 1, 6'd2, 0, 0, 6'd0, 32'h0, 1, 32'hA000_0002, 0, 0);

    // Store then load same word
    step(1, 0, 6'd0, 1, 1, 6'd4, 32'hDEAD_BEEF, 3, 32'h0, 0, 0);
    step(1, 0, 6'd0, 1, 0, 6'd4, 32'h0, 2, 32'hDEAD_BEEF, 0, 0);
    step(1, 0, 6'd0, 0, 0, 6'd0, 32'h0, 0, 32'h0, 0, 0);

    // Starvation clear by dropping if_req
    step(1, 1, 6'd7, 1, 0, 6'd5, 32'h0, 2, 32'hA000_0005, 0, 0);
    step(1, 1, 6'd7, 1, 0, 6'd5, 32'h0, 2, 32'hA000_0005, 1, 0);
    step(1, 0, 6'd7, 1, 0, 6'd5, 32'h0, 2, 32'hA000_0005, 2, 0);
    step(1, 1, 6'd7, 1, 0, 6'd5, 32'h0, 2, 32'hA000_0005, 0, 0);
    step(1, 1, 6'd7, 1, 0, 6'd5, 32'h0, 2, 32'hA000_0005, 1, 0);
    step(1, 1, 6'd7, 1, 0, 6'd5, 32'h0, 2, 32'hA000_0005, 2, 0);
    step(1, 1, 6'd7, 1, 0, 6'd5, 32'h0, 1, 32'hA000_0007, 3, 0);
    step(1, 0, 6'd0, 0, 0, 6'd0, 32'h0, 0, 32'h0, 0, 0);

    // Reset right after a fetch grant: no response may appear
    step(1, 1, 6'd9, 0, 0, 6'd0, 32'h0, 1, 32'hA000_0009, 0, 1);
    step(0, 0, 6'd0, 0, 0, 6'd0, 32'h0, 0, 32'h0, 0, 0);
    chk("own_after_reset", 64'(dbg_own_o), 64'(OWN_NONE));
    step(1, 1, 6'd9, 0, 0, 6'd0, 32'h0, 1, 32'hA000_0009, 0, 0);
    step(1, 0, 6'd0, 0, 0, 6'd0, 32'h0, 0, 32'h0, 0, 0);
    step(1, 0, 6'd0, 0, 0, 6'd0, 32'h0, 0, 32'h0, 0, 0);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Arbitrates a single-ported, synchronous-read unified memory between the pipeline's instruction-fetch port and its data (load/store) port. Data accesses normally win. A saturating starvation counter forces one fetch grant after `MAX_WAIT` consecutive fetch denials. Requesters see combinational stalls and a one-cycle-later read response routed by a registered owner tag. The block sits between the IF/MEM stages and the shared memory array that replaces the separate instruction memory.

## Interface
- `AW`, 6: word-address width (64-word memory).
- `DW`, 32: data width.
- `MAX_WAIT`, 3: consecutive fetch denials before the fetch is forced; legal range ≥1.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset: synchronous, active-low.
- `if_req`  in  1  fetch request.
- `if_addr`  in  AW  fetch word address.
- `if_stall`  out  1  fetch not granted this cycle.
- `if_valid`  out  1  fetch data valid (one cycle after grant).
- `if_rdata`  out  DW  fetched instruction.
- `d_req`  in  1  data request.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  AW  data word address.
- `d_wdata`  in  DW  store data.
- `d_stall`  out  1  data not granted this cycle.
- `d_valid`  out  1  load data valid / store acknowledged (one cycle after grant).
- `d_rdata`  out  DW  load data.
- `mem_en`  out  1  memory access this cycle.
- `mem_we`  out  1  memory write.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data; valid the cycle after `mem_en`.

## Operation
- `force_if = if_req && (starve_cnt == MAX_WAIT)`.
- `grant_d = rst && d_req && !force_if`.
- `grant_if = rst && if_req && !grant_d`.
- `if_stall = if_req && !grant_if`; `d_stall = d_req && !grant_d`. Both are combinational and remain asserted while `rst` is low.
- `mem_en = grant_d || grant_if`; `mem_we = grant_d && d_we`.
- `mem_addr` and `mem_wdata` come from the granted port. When there is no grant they are 0.
- Owner register `own` has states `OWN_NONE`, `OWN_IF`, `OWN_D_RD`, `OWN_D_WR`:
  - next value is `OWN_IF` on `grant_if`;
  - `OWN_D_RD` or `OWN_D_WR` on `grant_d`, per `d_we`;
  - otherwise `OWN_NONE`.
- Response outputs:
  - `if_valid = (own == OWN_IF)`.
  - `d_valid = (own == OWN_D_RD || own == OWN_D_WR)`.
  - `if_rdata = mem_rdata` when `own == OWN_IF`, else 0.
  - `d_rdata = mem_rdata` when `own == OWN_D_RD`, else 0. A store ack returns `d_rdata = 0`.
- Starvation counter `starve_cnt`, width `$clog2(MAX_WAIT+1)`:
  - increments on `if_req && !grant_if`, saturating at `MAX_WAIT`;
  - clears to 0 on `grant_if` or `!if_req`.
- A requester holds `req`, `addr`, `wdata` and `we` stable while stalled. The arbiter does not latch requests.

## Timing
- Reset (`rst` low at an edge) sets `own = OWN_NONE` and `starve_cnt = 0`.
- Output values while `rst` is low:
  - `if_valid`, `d_valid`, `if_rdata`, `d_rdata`, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata` are all 0.
  - `if_stall = if_req`; `d_stall = d_req`.
- Reset mid-access: a grant issued in the cycle before reset produces no valid response. `own` is cleared at the reset edge.
- Latency: grant in cycle t gives valid/rdata in cycle t+1. Throughput is one access per cycle, with back-to-back grants allowed.
- Both ports requesting continuously with `MAX_WAIT = 3` gives a repeating grant pattern D, D, D, IF; the fetch wins every fourth cycle.
- A fetch-only request is granted the same cycle regardless of `starve_cnt`.
- `if_req` dropping while starved clears the counter. The next fetch starts counting from 0.
- A store granted in cycle t is visible to a load or fetch granted in cycle t+1 or later.

## Structure
- Package `mem_arb_pkg` holds:
  - owner enum (`OWN_NONE`, `OWN_IF`, `OWN_D_RD`, `OWN_D_WR`);
  - default constants `AW_DEF = 6`, `DW_DEF = 32`, `MAX_WAIT_DEF = 3`.
- One sub-module, `starve_counter`: saturating counter with `inc`, `clr` and `sat` outputs, parameterised by `MAX_WAIT`.
- Arbitration, muxes and the owner register stay in the top level.

## Test plan
- Reset: hold `rst = 0` with both requests high for 3 cycles. Required: `mem_en = 0`, both stalls = 1, both valids = 0. Release; cycle 1 grants data.
- Fetch only: `if_req` with addresses 0, 1, 2 on consecutive cycles and memory preloaded. Required: `if_stall = 0` throughout, and `if_valid` with the matching `if_rdata` one cycle after each address.
- Conflict, `MAX_WAIT = 3`: both requests held high for 8 cycles. Required: grant order D, D, D, IF, D, D, D, IF, and `if_stall` low only in cycles 3 and 7.
- Store then load: store `d_addr = 4`, `d_wdata = 0xDEADBEEF`, then load `d_addr = 4`. Required:
  - first `d_valid` with `d_rdata = 0`;
  - second `d_valid` with `d_rdata = 0xDEADBEEF`;
  - `mem_we = 1` only in the store cycle.
- Starvation clear: fetch denied for 2 cycles, `if_req` dropped for 1 cycle, then both requesting. Required: `starve_cnt` returns to 0, and 3 further data grants precede the fetch grant.
- Reset mid-access: fetch granted at cycle t, `rst` low at edge t+1. Required: `if_valid = 0` at t+1 and `own = OWN_NONE`.
